// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // Bit-counter width: enough to count 0..w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// Half-subtractor cell: difference and borrow-out of x - y.
// Purely combinational; two of these plus an OR form one full subtractor.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first; result valid WIDTH cycles after accept.
// Holds diff/borrow while out_ready is low; in_ready high only when idle.
// SERIAL_SUB_ZERO_FLAG_EN adds a serially-built zero flag output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;

  logic d1, bo1, d_bit, bo2, bout;

  // Full subtractor: (a - b) first, then subtract the incoming borrow.
  half_subtractor u_hs_ab (
    .x  (a_sr_q[0]),
    .y  (b_sr_q[0]),
    .d  (d1),
    .bo (bo1)
  );

  half_subtractor u_hs_bin (
    .x  (d1),
    .y  (brw_q),
    .d  (d_bit),
    .bo (bo2)
  );

  assign bout = bo1 | bo2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    brw_d     = brw_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d  = {d_bit, res_q[WIDTH-1:1]};
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        brw_d  = bout;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registers only move in SHIFT, so these are stable for the whole DONE phase.
  assign diff   = res_q;
  assign borrow = brw_q;

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic nz_q, nz_d;

  always_comb begin
    nz_d = nz_q;
    if (state_q == IDLE && in_valid) begin
      nz_d = 1'b0;
    end else if (state_q == SHIFT) begin
      nz_d = nz_q | d_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_q <= 1'b0;
    end else begin
      nz_q <= nz_d;
    end
  end

  assign zero = (state_q == DONE) & ~nz_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic         zero;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation with out_ready already set; checks latency and result.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_d, input logic exp_b, input logic exp_z);
    int lat;
    @(negedge clk);
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check({tag, "_diff"}, 32'(diff), 32'(exp_d));
    check({tag, "_borrow"}, 32'(borrow), 32'(exp_b));
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    check({tag, "_zero"}, 32'(zero), 32'(exp_z));
`else
    if (exp_z === 1'bx) check({tag, "_unused"}, 32'd0, 32'd1);
`endif
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] hold_d;
    logic         hold_b;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int pulses, sent, rcvd, cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    check("rst_zero", 32'(zero), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a shift discards the operation.
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'h01;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_borrow", 32'(borrow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 3 * W; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("midrst_no_out", 32'(pulses), 32'd0);
    check("midrst_ready_after", 32'(in_ready), 32'd1);

    run_op("basic", 8'd200, 8'd55, 8'd145, 1'b0, 1'b0);
    run_op("wrap1", 8'd3, 8'd5, 8'hFE, 1'b1, 1'b0);
    run_op("wrap2", 8'd0, 8'hFF, 8'h01, 1'b1, 1'b0);
    run_op("equal", 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1);
    run_op("msb", 8'h80, 8'h00, 8'h80, 1'b0, 1'b0);

    // Backpressure: result must hold and new operands must be refused.
    out_ready = 1'b0;
    run_op("bp", 8'd10, 8'd20, 8'hF6, 1'b1, 1'b0);
    hold_d = diff;
    hold_b = borrow;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        in_valid = 1'b1;
        a = 8'd7;
        b = 8'd1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_diff_hold", 32'(diff), 32'(hold_d));
      check("bp_borrow_hold", 32'(borrow), 32'(hold_b));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 32'(out_valid), 32'd0);
    run_op("bp_next", 8'd7, 8'd1, 8'd6, 1'b0, 1'b0);

    // Random traffic with random handshakes on both sides.
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    while ((sent < 1000 || rcvd < 1000) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (in_valid && in_ready) begin
        qa.push_back(a);
        qb.push_back(b);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (qa.size() == 0) begin
          check("rnd_spurious", 32'd1, 32'd0);
        end else begin
          logic [W-1:0] ea, eb;
          ea = qa.pop_front();
          eb = qb.pop_front();
          check("rnd_diff", 32'(diff), 32'(W'(ea - eb)));
          check("rnd_borrow", 32'(borrow), 32'(ea < eb));
        end
        rcvd++;
      end
    end
    in_valid = 1'b0;
    check("rnd_sent", 32'(sent), 32'd1000);
    check("rnd_rcvd", 32'(rcvd), 32'd1000);
    check("rnd_queue_empty", 32'(qa.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
